y86_alu_pipe: RTL and testbench
===============================

Name: y86_alu_pipe

Overview:
- Parametrised, pipelined successor to the combinational 64-bit AND slice of the Y86-64 ALU.
- Performs the four Y86 OPq functions (add, sub, and, xor) on WIDTH-bit operands and produces per-result ZF/SF/OF flags.
- Results pass through a STAGES-deep registered pipeline with a valid/ready handshake.
- Holds the architectural condition-code (CC) register, updated on result acceptance. Sits in the execute stage of the pipelined processor.

Parameters:
- WIDTH, 64, operand/result width in bits (legal ≥ 4).
- STAGES, 2, pipeline depth = latency in cycles (legal 1..4).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- ifun  in  4  0=ADD, 1=SUB, 2=AND, 3=XOR; 4..15 illegal
- a  in  WIDTH  operand valA (rA)
- b  in  WIDTH  operand valB (rB)
- set_cc  in  1  this beat updates the CC register on acceptance
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  valE
- res_zf, res_sf, res_of  out  1 each  flags of the current result
- err  out  1  current result came from an illegal ifun
- cc  out  3  architectural CC register {ZF,SF,OF}

Behaviour:
- Reset (async, rst_n=0): all stage valids=0, out_valid=0, result=0, res_*=0, err=0, cc=3'b100 (ZF=1, Y86 default). Reset mid-operation discards all in-flight beats; no CC update.
- Arithmetic, computed combinationally and captured in stage 1:
  - ADD: b+a.
  - SUB: b−a (Y86 subq rA,rB).
  - AND: b&a.
  - XOR: b^a.
  - All results modulo 2^WIDTH; carry out discarded.
- Flags:
  - ZF = (result==0); SF = result[WIDTH-1].
  - OF for ADD: a, b same sign and result sign differs.
  - OF for SUB: a, b differ in sign and result sign ≠ b sign.
  - OF = 0 for AND/XOR.
- Illegal ifun: result=0, ZF=1, SF=0, OF=0, err=1, and the beat never updates cc even when set_cc=1.
- Pipeline:
  - STAGES register stages, each holding {valid, result, flags, err, set_cc}.
  - Global advance = !out_valid | out_ready. When advance=1 all stages shift; when 0 all stages hold.
  - in_ready = advance (combinational from out_valid/out_ready; no combinational path from in_valid).
  - Accept on in_valid & in_ready. A non-accepted cycle inserts a bubble (valid=0) into stage 1.
  - Latency: a beat accepted at edge N appears at out_valid after edge N+STAGES-1, i.e. with STAGES=1 the result is visible the cycle after acceptance.
  - Throughput: 1 beat/cycle when out_ready is held high.
- Backpressure:
  - out_valid=1 & out_ready=0 freezes the whole pipeline.
  - result and flags stay stable until accepted.
  - in_ready=0 while frozen.
- CC update: on out_valid & out_ready & set_cc & !err, cc ← {res_zf,res_sf,res_of} at that edge. cc changes at no other time.
- Simultaneous events: accept and output handshake in the same cycle are legal. The CC update and the pipeline shift occur on the same edge.

Optional Feature:
- Macro: Y86_ALU_CARRY_EN.
- Defined:
  - Extra output res_cf (1 bit) = carry out of ADD or borrow of SUB (b<a unsigned); 0 for AND/XOR/illegal.
  - res_cf is carried through the pipeline; cc widens to 4 bits {ZF,SF,OF,CF} with CF reset value 0.
- Undefined: no res_cf port; cc is 3 bits as above.

Decomposition:
- Package y86_alu_pkg:
  - ifun constants ALU_ADD=4'h0, ALU_SUB=4'h1, ALU_AND=4'h2, ALU_XOR=4'h3.
  - CC reset constant CC_RESET=3'b100.
  - Flag bit indices CC_ZF=2, CC_SF=1, CC_OF=0.
- Sub-module y86_alu_core: purely combinational WIDTH-parametrised op/flag computation.
- The top level holds the pipeline registers, handshake and CC register.

Test Plan:
- Reset, STAGES=2: hold rst_n=0, then release → out_valid=0, cc=3'b100, in_ready=1.
- ADD overflow, WIDTH=64:
  - Stimulus: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, ifun=0, set_cc=1, out_ready=1.
  - Two cycles later: result=64'h8000_0000_0000_0000, res_sf=1, res_of=1, res_zf=0.
  - On acceptance: cc=3'b011.
- SUB zero: a=b=64'h1234, ifun=1 → result=0, res_zf=1, res_of=0. With set_cc=0, cc remains unchanged.
- Backpressure:
  - Stream 4 ADD beats (a=i, b=0) with out_ready=0 for 3 cycles.
  - in_ready=0 while out_valid=1; result stays 0 and is stable.
  - After out_ready=1, results 0,1,2,3 emerge in order with no loss or duplication.
- Illegal op: ifun=7, a=5, b=9, set_cc=1 → result=0, err=1, res_zf=1; cc not updated.
- Async reset mid-stream: assert rst_n=0 between edges while 2 beats are in flight → out_valid=0 immediately. After release, no stale beats emerge and cc=3'b100.

Source files
------------

// File: rtl/y86_alu_pkg.sv
// Shared constants for the pipelined Y86-64 execute-stage ALU.
// Y86_ALU_CARRY_EN widens the CC register with a carry/borrow flag.
package y86_alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [2:0] CC_RESET = 3'b100;

  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 0;

`ifdef Y86_ALU_CARRY_EN
  localparam int unsigned CC_W = 4;
  localparam logic [CC_W-1:0] CC_RESET_FULL = {CC_RESET, 1'b0};
`else
  localparam int unsigned CC_W = 3;
  localparam logic [CC_W-1:0] CC_RESET_FULL = CC_RESET;
`endif

endpackage

// File: rtl/y86_alu_core.sv
// Combinational Y86 OPq datapath: result and ZF/SF/OF (plus CF when
// Y86_ALU_CARRY_EN is defined); illegal ifun yields a zero result and err.
module y86_alu_core
  import y86_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of,
`ifdef Y86_ALU_CARRY_EN
  output logic             cf,
`endif
  output logic             err
);

  localparam int unsigned Msb = WIDTH - 1;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

`ifdef Y86_ALU_CARRY_EN
  logic carry;
  logic borrow;
  assign {carry, sum}   = {1'b0, b} + {1'b0, a};
  assign {borrow, diff} = {1'b0, b} - {1'b0, a};
`else
  assign sum  = b + a;
  assign diff = b - a;
`endif

  always_comb begin
    result = '0;
    of     = 1'b0;
    err    = 1'b0;
`ifdef Y86_ALU_CARRY_EN
    cf     = 1'b0;
`endif
    case (ifun)
      ALU_ADD: begin
        result = sum;
        of     = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
`ifdef Y86_ALU_CARRY_EN
        cf     = carry;
`endif
      end
      ALU_SUB: begin
        // subq rA,rB computes rB - rA
        result = diff;
        of     = (a[Msb] != b[Msb]) && (diff[Msb] != b[Msb]);
`ifdef Y86_ALU_CARRY_EN
        cf     = borrow;
`endif
      end
      ALU_AND: result = b & a;
      ALU_XOR: result = b ^ a;
      default: err = 1'b1;
    endcase
    zf = (result == '0);
    sf = result[Msb];
  end

endmodule

// File: rtl/y86_alu_pipe.sv
// Pipelined Y86 ALU with valid/ready handshake and architectural CC register.
// Y86_ALU_CARRY_EN adds res_cf and widens cc to {ZF,SF,OF,CF}.
module y86_alu_pipe
  import y86_alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             res_zf,
  output logic             res_sf,
  output logic             res_of,
`ifdef Y86_ALU_CARRY_EN
  output logic             res_cf,
`endif
  output logic             err,
  output logic [CC_W-1:0]  cc
);

  // Stage payload layout: {[cf], set_cc, err, zf, sf, of, result}
  localparam int unsigned POf  = WIDTH;
  localparam int unsigned PSf  = WIDTH + 1;
  localparam int unsigned PZf  = WIDTH + 2;
  localparam int unsigned PErr = WIDTH + 3;
  localparam int unsigned PSet = WIDTH + 4;
  localparam int unsigned PW   = WIDTH + 5 + CC_W - 3;
  localparam int unsigned Last = STAGES - 1;
  localparam int unsigned CcOfs = CC_W - 3;

  logic [WIDTH-1:0] core_res;
  logic             core_zf;
  logic             core_sf;
  logic             core_of;
  logic             core_err;
`ifdef Y86_ALU_CARRY_EN
  localparam int unsigned PCf = WIDTH + 5;
  logic             core_cf;
`endif

  y86_alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .ifun   (ifun),
    .a      (a),
    .b      (b),
    .result (core_res),
    .zf     (core_zf),
    .sf     (core_sf),
    .of     (core_of),
`ifdef Y86_ALU_CARRY_EN
    .cf     (core_cf),
`endif
    .err    (core_err)
  );

  logic                       advance;
  logic [PW-1:0]              pay_d;
  logic [STAGES-1:0]          vld_q;
  logic [STAGES-1:0][PW-1:0]  pay_q;
  logic [CC_W-1:0]            cc_q;
  logic [CC_W-1:0]            cc_new;
  logic                       cc_upd;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    pay_d                = '0;
    pay_d[WIDTH-1:0]     = core_res;
    pay_d[POf]           = core_of;
    pay_d[PSf]           = core_sf;
    pay_d[PZf]           = core_zf;
    pay_d[PErr]          = core_err;
    pay_d[PSet]          = set_cc;
`ifdef Y86_ALU_CARRY_EN
    pay_d[PCf]           = core_cf;
`endif
  end

  // Single global enable: the whole pipe shifts or the whole pipe holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      pay_q <= '0;
    end else if (advance) begin
      vld_q[0] <= in_valid;
      pay_q[0] <= pay_d;
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        pay_q[i] <= pay_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[Last];
  assign result    = pay_q[Last][WIDTH-1:0];
  assign res_of    = pay_q[Last][POf];
  assign res_sf    = pay_q[Last][PSf];
  assign res_zf    = pay_q[Last][PZf];
  assign err       = pay_q[Last][PErr];
`ifdef Y86_ALU_CARRY_EN
  assign res_cf    = pay_q[Last][PCf];
`endif

  always_comb begin
    cc_new               = '0;
    cc_new[CC_ZF + CcOfs] = res_zf;
    cc_new[CC_SF + CcOfs] = res_sf;
    cc_new[CC_OF + CcOfs] = res_of;
`ifdef Y86_ALU_CARRY_EN
    cc_new[0]            = res_cf;
`endif
  end

  assign cc_upd = out_valid && out_ready && pay_q[Last][PSet] && !err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= CC_RESET_FULL;
    end else if (cc_upd) begin
      cc_q <= cc_new;
    end
  end

  assign cc = cc_q;

endmodule

// File: tb/tb_y86_alu_pipe.sv
// Self-checking bench for y86_alu_pipe (default build, WIDTH=64, STAGES=2).
module tb_y86_alu_pipe;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned STAGES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  ifun = 4'h0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        set_cc = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        res_zf;
  logic        res_sf;
  logic        res_of;
  logic        err;
  logic [2:0]  cc;

  y86_alu_pipe #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ifun     (ifun),
    .a        (a),
    .b        (b),
    .set_cc   (set_cc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .res_zf   (res_zf),
    .res_sf   (res_sf),
    .res_of   (res_of),
    .err      (err),
    .cc       (cc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] res;
    logic [2:0]  flags;
    logic        err;
    logic        sc;
  } exp_t;

  typedef struct {
    logic [3:0]  ifun;
    logic [63:0] a;
    logic [63:0] b;
    logic        sc;
    logic [63:0] res;
    logic [2:0]  flags;
    logic        err;
    logic [2:0]  cc;
  } vec_t;

  // Reference: overflow means the exact signed result does not fit in 64 bits.
  function automatic exp_t model(input logic [3:0] f, input logic [63:0] x,
                                 input logic [63:0] y, input logic sc);
    exp_t e;
    logic signed [65:0] sx, sy, full;
    sx = $signed(x);
    sy = $signed(y);
    e.res = '0;
    e.err = 1'b0;
    full  = '0;
    case (f)
      4'd0: begin e.res = y + x; full = sy + sx; end
      4'd1: begin e.res = y - x; full = sy - sx; end
      4'd2: begin e.res = y & x; full = {{2{e.res[63]}}, e.res}; end
      4'd3: begin e.res = y ^ x; full = {{2{e.res[63]}}, e.res}; end
      default: e.err = 1'b1;
    endcase
    if (e.err) full = '0;
    e.flags = {e.res == 64'd0, e.res[63], full != {{2{e.res[63]}}, e.res}};
    e.sc = sc;
    return e;
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 4))
      0: return 64'h8000_0000_0000_0000;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'($urandom_range(0, 3));
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  vec_t        vecs[10];
  exp_t        q[$];
  exp_t        e;
  logic [2:0]  cc_m;
  logic        was_stalled;
  logic [63:0] held_res;
  int          lat;
  int          sent;
  int          recv;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1,
                64'h8000_0000_0000_0000, 3'b011, 1'b0, 3'b011};
    vecs[1] = '{4'h1, 64'h1234, 64'h1234, 1'b0, 64'h0, 3'b100, 1'b0, 3'b011};
    vecs[2] = '{4'h2, 64'hF0F0, 64'hFF00, 1'b1, 64'hF000, 3'b000, 1'b0, 3'b000};
    vecs[3] = '{4'h3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0F, 1'b1,
                64'hFFFF_FFFF_FFFF_FFF0, 3'b010, 1'b0, 3'b010};
    vecs[4] = '{4'h1, 64'h1, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010, 1'b0, 3'b010};
    vecs[5] = '{4'h1, 64'h1, 64'h8000_0000_0000_0000, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 3'b001, 1'b0, 3'b001};
    vecs[6] = '{4'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
                64'h0, 3'b101, 1'b0, 3'b101};
    vecs[7] = '{4'h7, 64'h5, 64'h9, 1'b1, 64'h0, 3'b100, 1'b1, 3'b101};
    vecs[8] = '{4'hF, 64'hFF, 64'h1, 1'b1, 64'h0, 3'b100, 1'b1, 3'b101};
    vecs[9] = '{4'h1, 64'h5, 64'h5, 1'b1, 64'h0, 3'b100, 1'b0, 3'b100};

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_out_valid", 64'(out_valid), 64'd0);
    chk("rst_hold_cc", 64'(cc), 64'(3'b100));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_cc", 64'(cc), 64'(3'b100));
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors, one beat at a time
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ifun = vecs[i].ifun;
      a = vecs[i].a;
      b = vecs[i].b;
      set_cc = vecs[i].sc;
      in_valid = 1'b1;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(STAGES - 1));
      chk($sformatf("vec%0d_result", i), result, vecs[i].res);
      chk($sformatf("vec%0d_flags", i), 64'({res_zf, res_sf, res_of}), 64'(vecs[i].flags));
      chk($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].err));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_cc", i), 64'(cc), 64'(vecs[i].cc));
      chk($sformatf("vec%0d_drained", i), 64'(out_valid), 64'd0);
    end

    // Backpressure: fill with out_ready low, hold, then release
    ifun = 4'h0;
    b = 64'd0;
    set_cc = 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    sent = 0;
    for (int c = 0; c < 4; c++) begin
      a = 64'(sent);
      #1;
      if (in_ready) sent++;
      @(posedge clk);
      #1;
    end
    chk("bp_filled", 64'(sent), 64'(STAGES));
    for (int c = 0; c < 3; c++) begin
      a = 64'(sent);
      #1;
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_result_hold", result, 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    recv = 0;
    for (int c = 0; c < 20 && recv < 4; c++) begin
      in_valid = (sent < 4);
      a = 64'(sent);
      #1;
      if (out_valid) begin
        chk("bp_order", result, 64'(recv));
        recv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(recv), 64'd4);
    for (int c = 0; c < 3; c++) begin
      chk("bp_no_dup", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    chk("bp_cc", 64'(cc), 64'(3'b000));

    // Async reset with two beats in flight
    ifun = 4'h0;
    a = 64'd5;
    b = 64'd5;
    set_cc = 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("ar_in_flight", 64'(out_valid), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid_now", 64'(out_valid), 64'd0);
    chk("ar_cc_now", 64'(cc), 64'(3'b100));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("ar_no_stale", 64'(out_valid), 64'd0);
    end
    chk("ar_cc_after", 64'(cc), 64'(3'b100));

    // Randomized stream against the reference model
    cc_m = 3'b100;
    was_stalled = 1'b0;
    held_res = '0;
    for (int c = 0; c < 420; c++) begin
      in_valid = (c < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = (c < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
      ifun = 4'($urandom_range(0, 5));
      a = rnd64();
      b = ($urandom_range(0, 4) == 0) ? a : rnd64();
      set_cc = 1'($urandom_range(0, 1));
      #1;
      if (was_stalled) chk("rnd_hold_stable", result, held_res);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd_unexpected_out: got result %h expected no beat", result);
        end else begin
          e = q.pop_front();
          chk("rnd_result", result, e.res);
          chk("rnd_flags", 64'({res_zf, res_sf, res_of}), 64'(e.flags));
          chk("rnd_err", 64'(err), 64'(e.err));
          if (e.sc && !e.err) cc_m = e.flags;
        end
      end
      if (in_valid && in_ready) q.push_back(model(ifun, a, b, set_cc));
      was_stalled = out_valid && !out_ready;
      held_res = result;
      @(posedge clk);
      #1;
      chk("rnd_cc", 64'(cc), 64'(cc_m));
    end
    chk("rnd_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
